// File: rtl/dac_pkg.sv
// Shared types and default timing for the parallel-DAC write controller.
package dac_pkg;

   // Write-cycle phases; IDLE is the only phase that accepts a sample.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } dac_state_e;

   localparam int DAC_DATA_W    = 8;
   localparam int DAC_SETUP_CYC = 1;
   localparam int DAC_WR_CYC    = 2;
   localparam int DAC_HOLD_CYC  = 1;

   // Width of the phase timer: it holds at most max(phase lengths)-1,
   // and never drops below one bit.
   function automatic int dac_timer_w(input int setup_cyc, input int wr_cyc,
                                      input int hold_cyc);
      int m;
      m = setup_cyc;
      if (wr_cyc > m)   m = wr_cyc;
      if (hold_cyc > m) m = hold_cyc;
      if (m <= 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/dac_write_ctrl_timer.sv
// Loadable down-counter that times the SETUP, STROBE and HOLD phases.
// A load takes priority; otherwise the count decrements and parks at zero.
module dac_cyc_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // Load or count down towards zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/dac_write_ctrl.sv
// Turns each accepted sample into one timed parallel-DAC write cycle.
//
// Handshake: a sample is taken on a clk_5M edge where sample_valid and
// sample_ready are both high; sample_ready is high only in IDLE, so the
// upstream stage may hold valid asserted and the next sample is taken in
// the IDLE cycle that carries write_done.
//
// All bus outputs (CS, WR, A/B, data) are flops loaded from the next-state
// decode, so they line up with the FSM phase without a combinational path
// from the inputs.
module dac_write_ctrl
   import dac_pkg::*;
#(
   parameter int DATA_W    = DAC_DATA_W,
   parameter int SETUP_CYC = DAC_SETUP_CYC,
   parameter int WR_CYC    = DAC_WR_CYC,
   parameter int HOLD_CYC  = DAC_HOLD_CYC,
   parameter int CNT_W     = 16
) (
   input  logic              clk_5M,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_chan,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              DAC_CS,
   output logic              DAC_WR,
   output logic              DACAB,
   output logic [DATA_W-1:0] DAC_DATA,
   output logic              write_done,
   output logic [CNT_W-1:0]  write_cnt
);

   localparam int TW = dac_timer_w(SETUP_CYC, WR_CYC, HOLD_CYC);

   localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] WR_LD    = TW'(WR_CYC - 1);
   localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

   // Current phase; kept as a named enum so checkers can bind to it.
   dac_state_e state;
   dac_state_e next_state;

   logic          tmr_load;
   logic [TW-1:0] tmr_load_val;
   logic          tmr_zero;
   logic          accept;
   logic          done_evt;

   assign accept = sample_valid && sample_ready;

   dac_cyc_timer #(
      .W(TW)
   ) u_timer (
      .clk      (clk_5M),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .zero     (tmr_zero)
   );

   // Phase sequencing and timer reloads at each phase boundary.
   always_comb begin
      next_state   = state;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      done_evt     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               next_state   = ST_SETUP;
               tmr_load     = 1'b1;
               tmr_load_val = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               next_state   = ST_STROBE;
               tmr_load     = 1'b1;
               tmr_load_val = WR_LD;
            end
         end
         ST_STROBE: begin
            if (tmr_zero) begin
               next_state   = ST_HOLD;
               tmr_load     = 1'b1;
               tmr_load_val = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               next_state = ST_IDLE;
               done_evt   = 1'b1;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State register plus the bus strobes decoded from the next phase.
   always_ff @(posedge clk_5M or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         DAC_CS       <= 1'b1;
         DAC_WR       <= 1'b1;
         sample_ready <= 1'b0;
      end else begin
         state        <= next_state;
         DAC_CS       <= (next_state == ST_IDLE);
         DAC_WR       <= (next_state != ST_STROBE);
         sample_ready <= (next_state == ST_IDLE);
      end
   end

   // Data and channel are captured only when a sample is accepted.
   always_ff @(posedge clk_5M or posedge rst) begin
      if (rst) begin
         DAC_DATA <= '0;
         DACAB    <= 1'b0;
      end else if (accept) begin
         DAC_DATA <= sample_in;
         DACAB    <= sample_chan;
      end
   end

   // Completion pulse and free-running (wrapping) write counter.
   always_ff @(posedge clk_5M or posedge rst) begin
      if (rst) begin
         write_done <= 1'b0;
         write_cnt  <= '0;
      end else begin
         write_done <= done_evt;
         if (done_evt) begin
            write_cnt <= write_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dac_write_ctrl.sv
// Directed bench for dac_write_ctrl: reset, single write timing,
// back-to-back writes, input glitches, mid-write reset and counter wrap.
module tb_dac_write_ctrl;

   logic       clk_5M       = 1'b0;
   logic       rst          = 1'b1;
   logic [7:0] sample_in    = 8'h00;
   logic       sample_chan  = 1'b0;
   logic       sample_valid = 1'b0;

   logic        sample_ready, DAC_CS, DAC_WR, DACAB, write_done;
   logic [7:0]  DAC_DATA;
   logic [15:0] write_cnt;

   logic        w_sample_ready, w_DAC_CS, w_DAC_WR, w_DACAB, w_write_done;
   logic [7:0]  w_DAC_DATA;
   logic [3:0]  w_write_cnt;

   int n_compared   = 0;
   int n_mismatched = 0;

   // ---------------- clock ----------------
   always #100 clk_5M = ~clk_5M;

   dac_write_ctrl dut (
      .clk_5M       (clk_5M),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_chan  (sample_chan),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .DAC_CS       (DAC_CS),
      .DAC_WR       (DAC_WR),
      .DACAB        (DACAB),
      .DAC_DATA     (DAC_DATA),
      .write_done   (write_done),
      .write_cnt    (write_cnt)
   );

   dac_write_ctrl #(.CNT_W(4)) dut_w4 (
      .clk_5M       (clk_5M),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_chan  (sample_chan),
      .sample_valid (sample_valid),
      .sample_ready (w_sample_ready),
      .DAC_CS       (w_DAC_CS),
      .DAC_WR       (w_DAC_WR),
      .DACAB        (w_DACAB),
      .DAC_DATA     (w_DAC_DATA),
      .write_done   (w_write_done),
      .write_cnt    (w_write_cnt)
   );

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk_5M);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_5M);
      rst = 1'b1;
      @(negedge clk_5M);
      rst = 1'b0;
      step();
   endtask

   // Wait (bounded) for ready, present one sample, run the write to the
   // write_done cycle.
   task automatic do_write(input logic [7:0] d, input logic ch, input string tag);
      int waited = 0;
      while (!sample_ready && waited < 20) begin
         step();
         waited++;
      end
      check_val({tag, "_ready"}, 32'(sample_ready), 32'd1);
      sample_in    = d;
      sample_chan  = ch;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      check_val({tag, "_data"}, 32'(DAC_DATA), 32'(d));
      repeat (4) step();
      check_val({tag, "_done"}, 32'(write_done), 32'd1);
   endtask

   // Expected strobe pattern after accept edge 0, sampled after edges 0..4.
   logic [4:0] exp_cs   = 5'b10000;
   logic [4:0] exp_wr   = 5'b11001;
   logic [4:0] exp_done = 5'b10000;

   initial begin : main
      bit seen_done;

      // 1. reset values while rst is high, ready on first edge after release
      repeat (2) @(posedge clk_5M);
      #1;
      check_val("rst_cs",    32'(DAC_CS),       32'd1);
      check_val("rst_wr",    32'(DAC_WR),       32'd1);
      check_val("rst_data",  32'(DAC_DATA),     32'd0);
      check_val("rst_ab",    32'(DACAB),        32'd0);
      check_val("rst_cnt",   32'(write_cnt),    32'd0);
      check_val("rst_ready", 32'(sample_ready), 32'd0);
      check_val("rst_done",  32'(write_done),   32'd0);
      @(negedge clk_5M);
      rst = 1'b0;
      step();
      check_val("post_rst_ready", 32'(sample_ready), 32'd1);

      // 2. single write, 0xA5 on channel B
      sample_in    = 8'hA5;
      sample_chan  = 1'b1;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      check_val("single_busy_ready", 32'(sample_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         check_val($sformatf("single_cs_%0d", i),   32'(DAC_CS),     32'(exp_cs[i]));
         check_val($sformatf("single_wr_%0d", i),   32'(DAC_WR),     32'(exp_wr[i]));
         check_val($sformatf("single_done_%0d", i), 32'(write_done), 32'(exp_done[i]));
         check_val($sformatf("single_data_%0d", i), 32'(DAC_DATA),   32'hA5);
         check_val($sformatf("single_ab_%0d", i),   32'(DACAB),      32'd1);
         if (i < 4) step();
      end
      check_val("single_cnt",   32'(write_cnt),    32'd1);
      check_val("single_ready", 32'(sample_ready), 32'd1);
      step();
      check_val("single_done_off", 32'(write_done), 32'd0);

      // 3. back-to-back with valid held high
      do_reset();
      check_val("b2b_cnt0", 32'(write_cnt), 32'd0);
      sample_chan  = 1'b0;
      sample_in    = 8'h10;
      sample_valid = 1'b1;
      step();
      check_val("b2b_data_10", 32'(DAC_DATA), 32'h10);
      sample_in = 8'h20;
      repeat (4) step();
      check_val("b2b_hold_10", 32'(DAC_DATA),   32'h10);
      check_val("b2b_done_1",  32'(write_done), 32'd1);
      step();
      check_val("b2b_data_20", 32'(DAC_DATA), 32'h20);
      check_val("b2b_cs_20",   32'(DAC_CS),   32'd0);
      sample_in = 8'h30;
      repeat (4) step();
      check_val("b2b_hold_20", 32'(DAC_DATA), 32'h20);
      step();
      check_val("b2b_data_30", 32'(DAC_DATA), 32'h30);
      sample_valid = 1'b0;
      repeat (4) step();
      check_val("b2b_cnt3", 32'(write_cnt), 32'd3);

      // 4. input glitch during STROBE is ignored until next IDLE
      sample_in    = 8'h55;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      step();
      check_val("glitch_strobe_wr", 32'(DAC_WR), 32'd0);
      sample_in    = 8'hFF;
      sample_valid = 1'b1;
      step();
      check_val("glitch_e2", 32'(DAC_DATA), 32'h55);
      step();
      check_val("glitch_e3", 32'(DAC_DATA), 32'h55);
      step();
      check_val("glitch_e4", 32'(DAC_DATA), 32'h55);
      step();
      check_val("glitch_e5", 32'(DAC_DATA), 32'hFF);
      sample_valid = 1'b0;
      repeat (4) step();
      check_val("glitch_cnt", 32'(write_cnt), 32'd5);

      // 5. reset during STROBE: immediate CS/WR high, no completion
      sample_in    = 8'h77;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      step();
      check_val("mid_strobe_wr", 32'(DAC_WR), 32'd0);
      @(negedge clk_5M);
      rst = 1'b1;
      #1;
      check_val("mid_rst_cs",   32'(DAC_CS),    32'd1);
      check_val("mid_rst_wr",   32'(DAC_WR),    32'd1);
      check_val("mid_rst_data", 32'(DAC_DATA),  32'd0);
      check_val("mid_rst_cnt",  32'(write_cnt), 32'd0);
      @(negedge clk_5M);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (write_done) seen_done = 1'b1;
      end
      check_val("mid_rst_no_done", 32'(seen_done), 32'd0);
      check_val("mid_rst_cnt_after", 32'(write_cnt), 32'd0);

      // 6. 4-bit counter wrap over 17 writes
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         do_write(8'(i), i[0], $sformatf("wrap_w%0d", i));
         check_val($sformatf("wrap_cnt16_%0d", i), 32'(write_cnt), 32'(i));
         if (i == 15) check_val("wrap_cnt4_15", 32'(w_write_cnt), 32'd15);
         if (i == 16) check_val("wrap_cnt4_16", 32'(w_write_cnt), 32'd0);
         if (i == 17) check_val("wrap_cnt4_17", 32'(w_write_cnt), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_compared, n_mismatched);
      $finish;
   end

endmodule
